// File: rtl/i2c_slave_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_fsm_pkg
// Description : Shared I2C state encodings and ACK/NACK bus levels.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_slave_fsm_pkg;

  localparam logic [3:0] c_IDLE      = 4'd0;
  localparam logic [3:0] c_ADDR      = 4'd1;
  localparam logic [3:0] c_ADDR_ACK  = 4'd2;
  localparam logic [3:0] c_RX_DATA   = 4'd3;
  localparam logic [3:0] c_RX_ACK    = 4'd4;
  localparam logic [3:0] c_TX_DATA   = 4'd5;
  localparam logic [3:0] c_TX_ACK    = 4'd6;
  localparam logic [3:0] c_WAIT_STOP = 4'd7;

  localparam logic c_ACK  = 1'b0;
  localparam logic c_NACK = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2c_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : i2c_sync_edge
// Description : Synchronizes scl/sda through matched flop chains and flags
//               scl edges plus START/STOP conditions.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl_s;
  logic                   w_sda_s;

  // Reset to the idle bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
      r_scl_d    <= w_scl_s;
      r_sda_d    <= w_sda_s;
    end
  end

  assign w_scl_s   = r_scl_sync[SYNC_STAGES-1];
  assign w_sda_s   = r_sda_sync[SYNC_STAGES-1];
  assign sda_level = w_sda_s;
  assign scl_rise  =  w_scl_s & ~r_scl_d;
  assign scl_fall  = ~w_scl_s &  r_scl_d;
  assign start_det =  w_scl_s &  r_scl_d &  r_sda_d & ~w_sda_s;
  assign stop_det  =  w_scl_s &  r_scl_d & ~r_sda_d &  w_sda_s;

endmodule
`default_nettype wire

// File: rtl/i2c_slave_fsm.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_fsm
// Description : I2C target FSM with address match, byte receive/transmit and
//               open-drain sda driver.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_fsm
  import i2c_slave_fsm_pkg::*;
#(
  parameter int                  ADDR_LEN    = 7,
  parameter int                  DATA_LEN    = 8,
  parameter logic [ADDR_LEN-1:0] SLAVE_ADDR  = 7'h56,
  parameter int                  SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scl,
  inout  wire                 sda,
  output logic [DATA_LEN-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  input  logic [DATA_LEN-1:0] tx_data,
  output logic                tx_ack,
  output logic                rw_out,
  output logic                busy,
  output logic [3:0]          state_slave
);

  localparam int CNT_W   = $clog2(ADDR_LEN + 2);
  localparam int SHIFT_W = (ADDR_LEN > DATA_LEN - 1) ? ADDR_LEN : DATA_LEN - 1;
  localparam logic [CNT_W-1:0] c_ADDR_LAST = CNT_W'(ADDR_LEN);
  localparam logic [CNT_W-1:0] c_DATA_LAST = CNT_W'(DATA_LEN - 1);
  localparam logic [CNT_W-1:0] c_DATA_END  = CNT_W'(DATA_LEN);

  logic w_sda_in, w_scl_rise, w_scl_fall, w_start, w_stop;

  logic [3:0]          r_state;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [SHIFT_W-1:0]  r_shift;
  logic [DATA_LEN-1:0] r_tx_shift;
  logic [DATA_LEN-1:0] r_rx_data;
  logic                r_rx_valid, r_tx_ack, r_rw, r_busy;
  logic                r_sda_low, r_phase, r_ack_bit;

  logic [ADDR_LEN:0]   w_addr_word;
  logic [DATA_LEN-1:0] w_rx_word;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (scl),
    .sda       (sda),
    .sda_level (w_sda_in),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop)
  );

  assign w_addr_word = {r_shift[ADDR_LEN-1:0], w_sda_in};
  assign w_rx_word   = {r_shift[DATA_LEN-2:0], w_sda_in};

  // r_phase splits the two-fall ACK slots: 0 = waiting to drive, 1 = driving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_ack   <= 1'b0;
      r_rw       <= 1'b0;
      r_busy     <= 1'b0;
      r_sda_low  <= 1'b0;
      r_phase    <= 1'b0;
      r_ack_bit  <= c_NACK;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_ack   <= 1'b0;
      if (w_start) begin
        r_state   <= c_ADDR;
        r_bit_cnt <= '0;
        r_sda_low <= 1'b0;
        r_phase   <= 1'b0;
      end else if (w_stop) begin
        r_state   <= c_IDLE;
        r_sda_low <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          c_ADDR: if (w_scl_rise) begin
            r_shift <= {r_shift[SHIFT_W-2:0], w_sda_in};
            if (r_bit_cnt == c_ADDR_LAST) begin
              if (w_addr_word[ADDR_LEN:1] == SLAVE_ADDR) begin
                r_rw    <= w_addr_word[0];
                r_busy  <= 1'b1;
                r_phase <= 1'b0;
                r_state <= c_ADDR_ACK;
              end else begin
                r_state <= c_WAIT_STOP;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
          c_ADDR_ACK: if (w_scl_fall) begin
            if (!r_phase) begin
              r_sda_low <= 1'b1;
              r_phase   <= 1'b1;
            end else if (r_rw) begin
              r_phase    <= 1'b0;
              r_tx_shift <= {tx_data[DATA_LEN-2:0], 1'b0};
              r_sda_low  <= ~tx_data[DATA_LEN-1];
              r_tx_ack   <= 1'b1;
              r_bit_cnt  <= CNT_W'(1);
              r_state    <= c_TX_DATA;
            end else begin
              r_phase   <= 1'b0;
              r_sda_low <= 1'b0;
              r_bit_cnt <= '0;
              r_state   <= c_RX_DATA;
            end
          end
          c_RX_DATA: if (w_scl_rise) begin
            r_shift <= {r_shift[SHIFT_W-2:0], w_sda_in};
            if (r_bit_cnt == c_DATA_LAST) begin
              r_rx_data  <= w_rx_word;
              r_rx_valid <= 1'b1;
              r_ack_bit  <= rx_ready ? c_ACK : c_NACK;
              r_phase    <= 1'b0;
              r_state    <= c_RX_ACK;
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
          c_RX_ACK: if (w_scl_fall) begin
            if (!r_phase) begin
              r_sda_low <= (r_ack_bit == c_ACK);
              r_phase   <= 1'b1;
            end else begin
              r_sda_low <= 1'b0;
              r_phase   <= 1'b0;
              r_bit_cnt <= '0;
              r_state   <= (r_ack_bit == c_ACK) ? c_RX_DATA : c_WAIT_STOP;
            end
          end
          c_TX_DATA: if (w_scl_fall) begin
            if (r_bit_cnt == c_DATA_END) begin
              r_sda_low <= 1'b0;
              r_state   <= c_TX_ACK;
            end else begin
              r_sda_low  <= ~r_tx_shift[DATA_LEN-1];
              r_tx_shift <= {r_tx_shift[DATA_LEN-2:0], 1'b0};
              r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
            end
          end
          // A NACK exits on the rise, so a fall here always follows an ACK.
          c_TX_ACK: begin
            if (w_scl_rise && (w_sda_in == c_NACK)) begin
              r_state <= c_WAIT_STOP;
            end else if (w_scl_fall) begin
              r_tx_shift <= {tx_data[DATA_LEN-2:0], 1'b0};
              r_sda_low  <= ~tx_data[DATA_LEN-1];
              r_tx_ack   <= 1'b1;
              r_bit_cnt  <= CNT_W'(1);
              r_state    <= c_TX_DATA;
            end
          end
          c_WAIT_STOP: r_sda_low <= 1'b0;
          default: begin
            r_state   <= c_IDLE;
            r_sda_low <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda         = r_sda_low ? 1'b0 : 1'bz;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_ack      = r_tx_ack;
  assign rw_out      = r_rw;
  assign busy        = r_busy;
  assign state_slave = r_state;

endmodule
`default_nettype wire
